// File: rtl/uart_parity_unit.sv
// uart_parity_unit
//   Parametrised UART parity generator (TX, parallel word, one-cycle registered)
//   and bit-serial parity checker (RX, LSB first, then the parity bit).
//   Parity modes on cfg_mode: 0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 none.
//   Optional feature: define UART_PARITY_ERRCNT_EN to build the saturating
//   parity-error counter on err_count; otherwise err_count is tied to zero.
//   Reset is synchronous and active-low on rst.
module uart_parity_unit #(
    parameter int DATA_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          cfg_mode,
    input  logic                gen_valid,
    input  logic [DATA_W-1:0]   gen_data,
    output logic                gen_parity,
    output logic                gen_parity_valid,
    output logic                gen_parity_en,
    input  logic                chk_start,
    input  logic                chk_bit_valid,
    input  logic                chk_bit,
    output logic                chk_busy,
    output logic                chk_done,
    output logic                chk_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [2:0] MODE_EVEN  = 3'd1;
    localparam logic [2:0] MODE_ODD   = 3'd2;
    localparam logic [2:0] MODE_MARK  = 3'd3;
    localparam logic [2:0] MODE_SPACE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_DONE = 2'd3
    } chk_state_e;

    // True when the mode appends a parity bit to the frame.
    function automatic logic needs_parity(input logic [2:0] mode);
        return (mode == MODE_EVEN) || (mode == MODE_ODD) ||
               (mode == MODE_MARK) || (mode == MODE_SPACE);
    endfunction

    // Parity bit for a word whose XOR-reduction is 'x_xor'.
    function automatic logic parity_of(input logic [2:0] mode, input logic x_xor);
        logic p;
        case (mode)
            MODE_EVEN: p = x_xor;
            MODE_ODD:  p = ~x_xor;
            MODE_MARK: p = 1'b1;
            default:   p = 1'b0;   // space, none and the unused codes
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Generator
    // ------------------------------------------------------------------
    logic gen_parity_q;
    logic gen_parity_valid_q;
    logic gen_parity_en_q;

    // Register parity for every accepted word; valid pulses for one cycle, data holds.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written only with non-blocking assignments so
        // every flop samples the pre-edge values regardless of statement order.
        if (!rst) begin
            gen_parity_q       <= 1'b0;
            gen_parity_valid_q <= 1'b0;
            gen_parity_en_q    <= 1'b0;
        end else begin
            gen_parity_valid_q <= gen_valid;
            if (gen_valid) begin
                gen_parity_q    <= parity_of(cfg_mode, ^gen_data);
                gen_parity_en_q <= needs_parity(cfg_mode);
            end
        end
    end

    assign gen_parity       = gen_parity_q;
    assign gen_parity_valid = gen_parity_valid_q;
    assign gen_parity_en    = gen_parity_en_q;

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    chk_state_e       state_q, state_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             err_q, err_d;

    // Checker state register and per-frame context.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: chk_start restarts a frame from any state and wins over a bit.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;

        if (chk_start) begin
            state_d = ST_DATA;
            acc_d   = 1'b0;
            cnt_d   = '0;
            mode_d  = cfg_mode;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // bits outside a frame are dropped
                end
                ST_DATA: begin
                    if (chk_bit_valid) begin
                        acc_d = acc_q ^ chk_bit;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_d = needs_parity(mode_q) ? ST_PAR : ST_DONE;
                        end
                    end
                end
                ST_PAR: begin
                    if (chk_bit_valid) begin
                        err_d   = (chk_bit != parity_of(mode_q, acc_q));
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign chk_busy = (state_q == ST_DATA) || (state_q == ST_PAR);
    assign chk_done = (state_q == ST_DONE);
    assign chk_err  = err_q;

    // ------------------------------------------------------------------
    // Optional saturating parity-error counter
    // ------------------------------------------------------------------
`ifdef UART_PARITY_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_count_q;

    // Count each completed frame that reported an error, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count_q <= '0;
        end else if ((state_q == ST_DONE) && err_q && (err_count_q != '1)) begin
            err_count_q <= err_count_q + ERRCNT_W'(1);
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule
